gray_rx_decoder: RTL

Downstream consumer of the 8-bit Gray-coded counter output, typically crossing into an unrelated clock domain. It synchronizes the Gray bus through a multi-flop chain and converts it to binary. It reports each new value with a one-cycle valid pulse and the step size since the previous value. It flags any sampled transition that changes more than one Gray bit, which indicates a coding or CDC violation.

---
 rtl/gray_rx_decoder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/gray_rx_decoder.sv
// Gray-code receiver: synchronizes an async Gray bus, decodes to binary,
// pulses valid on change, reports step size and flags multi-bit hops.
module gray_rx_decoder #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clear,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic [WIDTH-1:0] step,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam logic [1:0] FLUSH = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  localparam logic [2:0] FLUSH_LAST = 3'(SYNC_STAGES - 1);

  logic [1:0]       state;
  logic [2:0]       flush_cnt;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] g_prev;
  logic [WIDTH-1:0] g_bin;
  logic [WIDTH-1:0] diff;
  logic             changed;
  logic             multi;

  function automatic logic [WIDTH-1:0] g2b(
    input logic [WIDTH-1:0] g
  );
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    g_s     = sync_q[SYNC_STAGES-1];
    g_bin   = g2b(g_s);
    diff    = g_s ^ g_prev;
    changed = (state == RUN) && (diff != '0);
    // more than one bit set <=> clearing the lowest set bit leaves some
    multi   = changed &&
              ((diff & (diff - WIDTH'(1))) != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FLUSH;
      flush_cnt <= '0;
      g_prev    <= '0;
      bin_out   <= '0;
      step      <= '0;
      bin_valid <= 1'b0;
    end else begin
      bin_valid <= 1'b0;
      unique case (1'b1)
        state == FLUSH: begin
          flush_cnt <= flush_cnt + 3'd1;
          if (flush_cnt == FLUSH_LAST) begin
            state <= PRIME;
          end
        end
        state == PRIME: begin
          g_prev  <= g_s;
          bin_out <= g_bin;
          state   <= RUN;
        end
        state == RUN: begin
          if (changed) begin
            g_prev    <= g_s;
            bin_out   <= g_bin;
            step      <= g_bin - bin_out;
            bin_valid <= 1'b1;
          end
        end
        default: begin
          state <= FLUSH;
        end
      endcase
    end
  end

  // a new error event outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (multi) begin
      err <= 1'b1;
      if (clear) begin
        err_cnt <= 8'd1;
      end else if (err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end else if (clear) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end
  end

endmodule
